uart_rx: RTL and testbench

UART receiver: recovers asynchronous serial frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity) from the `rx` line. It uses the shared oversampling tick `s_tick`, which fires SB_TICKS times per bit period. Each received word is presented on `dout` with a one-cycle `rx_done_tick` strobe. It is the receive-side counterpart of the UART transmitter and feeds the UART interface FIFO/controller.

---
 rtl/uart_rx_if.sv | 19 +
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: oversampling tick and serial line in, word and strobe out.
// frame_err is present only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_tick;
    logic                 rx;
    logic                 rx_done_tick;
    logic [DATA_BITS-1:0] dout;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 frame_err;

    modport slave  (input s_tick, rx, output rx_done_tick, dout, frame_err);
    modport master (output s_tick, rx, input rx_done_tick, dout, frame_err);
`else
    modport slave  (input s_tick, rx, output rx_done_tick, dout);
    modport master (output s_tick, rx, input rx_done_tick, dout);
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, oversampled by s_tick.
// Optional UART_RX_FRAME_ERR_EN adds a registered frame_err flag from the stop-bit sample.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int SW = (SB_TICKS > 2) ? $clog2(SB_TICKS) : 1;
    localparam int NW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_HALF = SW'(SB_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [SW-1:0]        s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] b;
    logic [DATA_BITS-1:0] dout_r;
    logic                 done_r;
    logic                 rx_meta;
    logic                 rx_s;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 ferr_r;
`endif

    // rx is asynchronous; both flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            dout_r <= '0;
            done_r <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s == S_HALF) begin
                            // A line that is high again at mid start bit was a glitch.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {rx_s, b[DATA_BITS-1:1]};
                            if (n == N_LAST) state <= STOP;
                            else             n     <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (s == S_LAST) begin
                            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                            state  <= IDLE;
                            dout_r <= b;
                            done_r <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                            ferr_r <= ~rx_s;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout         = dout_r;
    assign bus.rx_done_tick = done_r;
`ifdef UART_RX_FRAME_ERR_EN
    assign bus.frame_err    = ferr_r;
`endif
    assign state_dbg        = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 with 16x ticks every 4 clk, and 7N1 with 8x ticks every clk.
// Frame-error checks are active when UART_RX_FRAME_ERR_EN is defined.
module tb_uart_rx;
  logic clk;
  logic reset;
  logic [1:0] state0;
  logic [1:0] state1;
  int total;
  int bad;
  int cyc;

  // Strobe cycle offsets from the negedge where rx falls, in posedges:
  // 1 + tick period * ticks from the first counted tick to the stop sample.
  localparam int OFF0 = 609;  // 4 * 152 + 1
  localparam int OFF1 = 71;   // ticks 3..70 at one per clk, + 1

  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  logic prev0;
  logic prev1;

  uart_rx_if #(.DATA_BITS(8)) if0 ();
  uart_rx_if #(.DATA_BITS(7)) if1 ();

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .state_dbg(state0)
  );
  uart_rx #(.DATA_BITS(7), .SB_TICKS(8)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .state_dbg(state1)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int inst, input logic r, input logic t);
    if (inst == 0) begin
      if0.rx = r;
      if0.s_tick = t;
    end else begin
      if1.rx = r;
      if1.s_tick = t;
    end
  endtask

  task automatic tick_once(input int inst, input logic r);
    int p;
    p = (inst == 0) ? 4 : 1;
    drive(inst, r, 1'b1);
    @(negedge clk);
    drive(inst, r, 1'b0);
    repeat (p - 1) @(negedge clk);
  endtask

  task automatic idle_ticks(input int inst, input int n);
    for (int i = 0; i < n; i++) tick_once(inst, 1'b1);
  endtask

  task automatic send(input int inst, input logic [7:0] data, input logic stop,
                      input logic [7:0] exp_d, input logic exp_f,
                      input int max_ticks, input bit push);
    int nb;
    int sb;
    int off;
    logic [40:0] e;
    nb  = (inst == 0) ? 8 : 7;
    sb  = (inst == 0) ? 16 : 8;
    off = (inst == 0) ? OFF0 : OFF1;
    e   = {32'(cyc + off), exp_f, exp_d};
    if (push) begin
      if (inst == 0) exp_q0.push_back(e);
      else           exp_q1.push_back(e);
    end
    for (int t = 0; t < (nb + 2) * sb && t < max_ticks; t++) begin
      int j;
      logic bv;
      j = t / sb;
      if (j == 0)       bv = 1'b0;
      else if (j <= nb) bv = data[j-1];
      // a bad stop bit recovers high in its last quarter so the next start edge is clean
      else              bv = stop | ((t % sb) >= (3 * sb / 4));
      tick_once(inst, bv);
    end
    drive(inst, 1'b1, 1'b0);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [40:0] e;
    if (if0.rx_done_tick) begin
      chk("strobe0_width", 64'(prev0), 64'd0);
      if (exp_q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe0_unexpected: got strobe dout=%0h expected none", if0.dout);
      end else begin
        e = exp_q0.pop_front();
        chk("dout0", 64'(if0.dout), 64'(e[7:0]));
        chk("strobe0_cycle", 64'(cyc), 64'(e[40:9]));
`ifdef UART_RX_FRAME_ERR_EN
        chk("frame_err0", 64'(if0.frame_err), 64'(e[8]));
`endif
      end
    end
    prev0 = if0.rx_done_tick;
  end

  always @(negedge clk) begin
    logic [40:0] e;
    if (if1.rx_done_tick) begin
      chk("strobe1_width", 64'(prev1), 64'd0);
      if (exp_q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe1_unexpected: got strobe dout=%0h expected none", if1.dout);
      end else begin
        e = exp_q1.pop_front();
        chk("dout1", 64'(if1.dout), 64'(e[6:0]));
        chk("strobe1_cycle", 64'(cyc), 64'(e[40:9]));
`ifdef UART_RX_FRAME_ERR_EN
        chk("frame_err1", 64'(if1.frame_err), 64'(e[8]));
`endif
      end
    end
    prev1 = if1.rx_done_tick;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    prev0 = 1'b0;
    prev1 = 1'b0;
    reset = 1'b1;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);

    vecs[0] = '{8'hA5, 1'b1, 32, 8'hA5, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 32, 8'h55, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 32, 8'h12, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 32, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_dout0", 64'(if0.dout), 64'd0);
    chk("rst_done0", 64'(if0.rx_done_tick), 64'd0);
    chk("rst_state0", 64'(state0), 64'd0);
    chk("rst_dout1", 64'(if1.dout), 64'd0);
    chk("rst_state1", 64'(state1), 64'd0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("rst_ferr0", 64'(if0.frame_err), 64'd0);
`endif
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // table: single frames, bad stop bit, recovery, and 0x00/0xFF back to back
    for (int i = 0; i < 5; i++) begin
      send(0, vecs[i].data, vecs[i].stop, vecs[i].exp_dout, vecs[i].exp_ferr, 1000, 1'b1);
      if (vecs[i].gap > 0) begin
        idle_ticks(0, vecs[i].gap);
        chk("drain0", 64'(exp_q0.size()), 64'd0);
      end
    end
    chk("table_last_dout0", 64'(if0.dout), 64'hFF);

    // false start: low for 3 ticks, then high through the mid start bit
    drive(0, 1'b0, 1'b0);
    for (int t = 0; t < 40; t++) tick_once(0, (t >= 3));
    chk("glitch_dout0", 64'(if0.dout), 64'hFF);
    chk("glitch_state0", 64'(state0), 64'd0);

    // asynchronous reset during data bit 3
    send(0, 8'h81, 1'b1, 8'h00, 1'b0, 72, 1'b0);
    chk("pre_rst_state0", 64'(state0), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_dout0", 64'(if0.dout), 64'd0);
    chk("async_rst_done0", 64'(if0.rx_done_tick), 64'd0);
    chk("async_rst_state0", 64'(state0), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h3C, 1'b1, 8'h3C, 1'b0, 1000, 1'b1);
    idle_ticks(0, 32);
    chk("drain0_after_rst", 64'(exp_q0.size()), 64'd0);
    chk("post_rst_dout0", 64'(if0.dout), 64'h3C);

    // 7 data bits, 8x oversampling, tick every clk
    send(1, 8'h5A, 1'b1, 8'h5A, 1'b0, 1000, 1'b1);
    idle_ticks(1, 16);
    chk("drain1", 64'(exp_q1.size()), 64'd0);
    chk("final_dout1", 64'(if1.dout), 64'h5A);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
